// File: rtl/mc_controller.sv
// ============================================================================
// Module   : mc_controller
// Brief    : Multi-cycle RV32 control FSM (Moore) driving datapath selects and
//            write strobes. Optional macro ILLEGAL_TRAP_EN adds a sticky TRAP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       illegal
);

    localparam logic [3:0] c_ST_FETCH     = 4'd0;
    localparam logic [3:0] c_ST_DECODE    = 4'd1;
    localparam logic [3:0] c_ST_MEM_ADR   = 4'd2;
    localparam logic [3:0] c_ST_MEM_READ  = 4'd3;
    localparam logic [3:0] c_ST_MEM_WB    = 4'd4;
    localparam logic [3:0] c_ST_MEM_WRITE = 4'd5;
    localparam logic [3:0] c_ST_EXEC_R    = 4'd6;
    localparam logic [3:0] c_ST_EXEC_I    = 4'd7;
    localparam logic [3:0] c_ST_LUI       = 4'd8;
    localparam logic [3:0] c_ST_ALU_WB    = 4'd9;
    localparam logic [3:0] c_ST_BRANCH    = 4'd10;
    localparam logic [3:0] c_ST_JAL       = 4'd11;
`ifdef ILLEGAL_TRAP_EN
    localparam logic [3:0] c_ST_TRAP      = 4'd12;
`endif

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = c_ST_FETCH;
        case (r_state)
            c_ST_FETCH:     w_next = mem_ready ? c_ST_DECODE : c_ST_FETCH;
            c_ST_DECODE: begin
                case (opcode)
                    c_OP_LOAD,
                    c_OP_STORE:  w_next = c_ST_MEM_ADR;
                    c_OP_R:      w_next = c_ST_EXEC_R;
                    c_OP_I:      w_next = c_ST_EXEC_I;
                    c_OP_BRANCH: w_next = c_ST_BRANCH;
                    c_OP_JAL:    w_next = c_ST_JAL;
                    c_OP_LUI:    w_next = c_ST_LUI;
`ifdef ILLEGAL_TRAP_EN
                    default:     w_next = c_ST_TRAP;
`else
                    default:     w_next = c_ST_FETCH;
`endif
                endcase
            end
            // opcode[5] separates store (0100011) from load (0000011)
            c_ST_MEM_ADR:   w_next = opcode[5] ? c_ST_MEM_WRITE : c_ST_MEM_READ;
            c_ST_MEM_READ:  w_next = mem_ready ? c_ST_MEM_WB : c_ST_MEM_READ;
            c_ST_MEM_WB:    w_next = c_ST_FETCH;
            c_ST_MEM_WRITE: w_next = mem_ready ? c_ST_FETCH : c_ST_MEM_WRITE;
            c_ST_EXEC_R,
            c_ST_EXEC_I,
            c_ST_LUI,
            c_ST_JAL:       w_next = c_ST_ALU_WB;
            c_ST_ALU_WB,
            c_ST_BRANCH:    w_next = c_ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
            c_ST_TRAP:      w_next = c_ST_TRAP;
`endif
            default:        w_next = c_ST_FETCH;
        endcase
    end

    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        case (r_state)
            c_ST_FETCH: begin
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                w_ir_write  = mem_ready;
                w_pc_update = mem_ready;
            end
            c_ST_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            c_ST_MEM_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            c_ST_MEM_READ:  adr_src = 1'b1;
            c_ST_MEM_WB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
            end
            c_ST_MEM_WRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
            end
            c_ST_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            c_ST_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            c_ST_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
            end
            c_ST_ALU_WB:    w_reg_write = 1'b1;
            c_ST_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                w_branch  = 1'b1;
            end
            c_ST_JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                w_pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are masked while reset is asserted so no write escapes mid-reset
    assign pc_write  = ~rst & (w_pc_update | (w_branch & zero));
    assign mem_write = ~rst & w_mem_write;
    assign ir_write  = ~rst & w_ir_write;
    assign reg_write = ~rst & w_reg_write;

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (r_state == c_ST_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// Module   : tb_mc_controller
// Brief    : Randomized scoreboard bench for mc_controller; expected per-cycle
//            outputs come from an instruction-phase model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_controller;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       illegal;

    mc_controller dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mr;
        logic        z;
        logic [6:0]  op;
        logic [13:0] exp;
        string       name;
    } cyc_t;

    // bit order: pc_write adr_src mem_write ir_write result_src a b alu_op reg_write illegal
    localparam logic [13:0] c_STROBES = 14'b1011_0000_0000_10;

    cyc_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cyc = 0;

    function automatic logic [13:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic rw, input logic ill);
        return {pcw, adr, mw, irw, rs, a, b, op, rw, ill};
    endfunction

    function automatic cyc_t mkc(input logic r, input logic mr, input logic z,
                                 input logic [6:0] op, input logic [13:0] e, input string nm);
        cyc_t c;
        c.rst = r; c.mr = mr; c.z = z; c.op = op; c.exp = e; c.name = nm;
        return c;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
               op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111 ||
               op == 7'b0110111;
    endfunction

    always @(negedge clk) begin
        n_cyc++;
        if (sb.size() != 0) begin
            cyc_t e;
            logic [13:0] act;
            e   = sb.pop_front();
            act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                   alu_src_b, alu_op, reg_write, illegal};
            n_vec++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s cyc=%0d op=%b actual=%b required=%b", e.name, n_cyc,
                         e.op, act, e.exp);
            end
        end
    end

    task automatic apply(input cyc_t c);
        @(posedge clk);
        #1;
        rst       = c.rst;
        mem_ready = c.mr;
        zero      = c.z;
        opcode    = c.op;
        sb.push_back(c);
    endtask

    // Builds the whole instruction as a list of cycles from its phase recipe,
    // then optionally replaces cycle abort_at with a reset and drops the rest.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input int abort_at);
        cyc_t q[$];
        logic m;
        logic z;
        for (int i = 0; i <= fw; i++) begin
            m = (i == fw);
            q.push_back(mkc(1'b0, m, rb(), 7'($urandom),
                mk(m, 1'b0, 1'b0, m, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0), "fetch"));
        end
        q.push_back(mkc(1'b0, rb(), rb(), op,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0), "decode"));
        case (op)
            7'b0000011, 7'b0100011: begin
                q.push_back(mkc(1'b0, rb(), rb(), op,
                    mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0), "mem_adr"));
                for (int i = 0; i <= mw; i++) begin
                    m = (i == mw);
                    if (op == 7'b0000011)
                        q.push_back(mkc(1'b0, m, rb(), op,
                            mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0), "mem_read"));
                    else
                        q.push_back(mkc(1'b0, m, rb(), op,
                            mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0), "mem_write"));
                end
                if (op == 7'b0000011)
                    q.push_back(mkc(1'b0, rb(), rb(), op,
                        mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0), "mem_wb"));
            end
            7'b0110011, 7'b0010011, 7'b0110111, 7'b1101111: begin
                if (op == 7'b0110011)
                    q.push_back(mkc(1'b0, rb(), rb(), op,
                        mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0), "exec_r"));
                else if (op == 7'b0010011)
                    q.push_back(mkc(1'b0, rb(), rb(), op,
                        mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0), "exec_i"));
                else if (op == 7'b0110111)
                    q.push_back(mkc(1'b0, rb(), rb(), op,
                        mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0), "lui"));
                else
                    q.push_back(mkc(1'b0, rb(), rb(), op,
                        mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0), "jal"));
                q.push_back(mkc(1'b0, rb(), rb(), op,
                    mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0), "alu_wb"));
            end
            7'b1100011: begin
                z = (mw > 1);
                q.push_back(mkc(1'b0, rb(), z, op,
                    mk(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0), "branch"));
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < int'($urandom_range(2, 5)); i++)
                    q.push_back(mkc(1'b0, rb(), rb(), 7'($urandom),
                        mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1), "trap"));
                q.push_back(mkc(1'b1, rb(), rb(), 7'($urandom),
                    mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1), "trap_rst"));
`endif
            end
        endcase
        if (abort_at >= 0 && abort_at < q.size()) begin
            q[abort_at].rst  = 1'b1;
            q[abort_at].exp  = q[abort_at].exp & ~c_STROBES;
            q[abort_at].name = {q[abort_at].name, "_rst"};
            while (q.size() > abort_at + 1) void'(q.pop_back());
        end
        foreach (q[i]) apply(q[i]);
    endtask

    initial begin
        logic [6:0] legal [7];
        logic [6:0] op;
        int         idx;
        legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                  7'b1100011, 7'b1101111, 7'b0110111};
        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 7'd0;
        apply(mkc(1'b1, 1'b1, 1'b0, 7'b0110011,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0), "reset"));

        run_instr(7'b0110011, 0, 0, -1);   // add, zero wait
        run_instr(7'b0000011, 0, 2, -1);   // lw, 2 wait cycles in MEM_READ
        run_instr(7'b1100011, 0, 2, -1);   // beq taken (zero=1)
        run_instr(7'b1100011, 0, 0, -1);   // beq not taken
        run_instr(7'b0100011, 1, 3, -1);   // sw, 3 wait cycles
        run_instr(7'b0100011, 0, 3, 4);    // reset during MEM_WRITE
        run_instr(7'b1111111, 0, 0, -1);   // illegal opcode
        run_instr(7'b0110011, 0, 0, -1);

        for (int n = 0; n < 300; n++) begin
            idx = $urandom_range(0, 8);
            if (idx < 7) begin
                op = legal[idx];
            end else begin
                op = 7'($urandom);
                while (is_legal(op)) op = 7'($urandom);
            end
            run_instr(op, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                      $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have one clock and synchronous active-high reset; ports listed clock and reset first.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 opcode  input  7  instruction bits [6:0] from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completes the current access this cycle.
REQ-007 pc_write  output  1  PC load enable, equal to pc_update OR (branch AND zero).
REQ-008 adr_src  output  1  memory address select for mux_2_to_1: 0 PC, 1 ALU result register.
REQ-009 mem_write  output  1  memory write strobe.
REQ-010 ir_write  output  1  instruction register and old-PC load enable.
REQ-011 result_src  output  2  mux_3_to_1 select: 00 ALU-out register, 01 memory data register, 10 ALU result.
REQ-012 alu_src_a  output  2  mux_4_to_1 select: 00 PC, 01 old PC, 10 register A, 11 zero.
REQ-013 alu_src_b  output  2  mux_3_to_1 select: 00 register B, 01 immediate, 10 constant 4.
REQ-014 alu_op  output  2  00 add, 01 subtract for branch compare, 10 funct decode.
REQ-015 reg_write  output  1  register file write enable.
REQ-016 illegal  output  1  illegal-opcode flag.

Function
REQ-017 SHALL be a Moore FSM with a registered state; outputs SHALL be decoded from the state, plus mem_ready and zero where stated.
REQ-018 Outputs not listed for a state SHALL be 0 and selects SHALL be 00; no select SHALL ever take an unlisted encoding.
REQ-019 FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10; ir_write and pc_update = mem_ready; stays in FETCH while mem_ready=0, else goes to DECODE.
REQ-020 DECODE: a=01, b=01, alu_op=00 (branch/jump target into ALU-out).
REQ-021 DECODE next state by opcode: 0000011 or 0100011 -> MEM_ADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; 0110111 -> LUI; any other -> REQ-033.
REQ-022 MEM_ADR: a=10, b=01, alu_op=00; goes to MEM_READ if opcode[5]=0, else MEM_WRITE.
REQ-023 MEM_READ: adr_src=1; holds until mem_ready, then goes to MEM_WB.
REQ-024 MEM_WB: result_src=01, reg_write=1; then FETCH.
REQ-025 MEM_WRITE: adr_src=1, mem_write=1, held every cycle until mem_ready; then FETCH.
REQ-026 EXEC_R: a=10, b=00, alu_op=10; then ALU_WB.
REQ-027 EXEC_I: a=10, b=01, alu_op=10; then ALU_WB.
REQ-028 LUI: a=11, b=01, alu_op=00; then ALU_WB.
REQ-029 ALU_WB: result_src=00, reg_write=1; then FETCH.
REQ-030 BRANCH: a=10, b=00, alu_op=01, result_src=00, branch=1 (pc_write=zero); then FETCH.
REQ-031 JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1; then ALU_WB (rd gets old PC+4).
REQ-032 Each instruction costs FETCH wait cycles plus: load 5, store 4, R/I/LUI/JAL 4, branch 3 cycles at zero wait.

Reset
REQ-033 Illegal opcode in DECODE: behaviour per the Configuration section.
REQ-034 rst=1 at a clock edge SHALL force state FETCH and clear illegal, overriding any transition, including mid-instruction and during a memory wait.
REQ-035 While rst=1, all strobes (pc_write, ir_write, mem_write, reg_write) SHALL be 0.

Configuration
REQ-036 Macro ILLEGAL_TRAP_EN defined: an illegal opcode SHALL enter TRAP, which holds with all strobes 0 and illegal=1 until reset.
REQ-037 ILLEGAL_TRAP_EN undefined: an illegal opcode SHALL return to FETCH with no writes, illegal SHALL be tied 0, and the TRAP state SHALL not exist.

Verification
REQ-038 add (0110011), mem_ready=1: FETCH, DECODE, EXEC_R, ALU_WB, FETCH; reg_write=1 only in ALU_WB; 4 cycles.
REQ-039 lw with mem_ready low 2 cycles in MEM_READ: MEM_READ lasts 3 cycles, adr_src=1 throughout, then MEM_WB has result_src=01 and reg_write=1.
REQ-040 beq with zero=1 gives pc_write=1 in BRANCH; with zero=0 gives pc_write=0; both return to FETCH next cycle.
REQ-041 sw with mem_ready=0 for 3 cycles: mem_write=1 for 4 consecutive cycles, then FETCH, with reg_write never asserted.
REQ-042 rst=1 in MEM_WRITE: the next state is FETCH and mem_write=0 in the reset cycle.
REQ-043 Opcode 1111111: with ILLEGAL_TRAP_EN, illegal=1 is sticky until rst; without it, FETCH follows DECODE and illegal stays 0.
